sram_line_fifo_ctrl: RTL and testbench

//  Initiator for the single-port wide SRAM macro interface. Packs a 16-bit word stream into
//  4-word lines and writes them to the SRAM as a circular line FIFO. Reads lines back and

---
 rtl/sram_ctrl_pkg.sv | 26 ++
 rtl/sram_line_serializer.sv | 50 +++++
 rtl/sram_line_fifo_ctrl.sv | 116 +++++++++++
 tb/tb_sram_line_fifo_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// ============================================================================
// Module : sram_ctrl_pkg
// Brief  : Shared widths, word/line types and arbiter grant encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sram_ctrl_pkg;

    localparam int WORD_WIDTH  = 16;
    localparam int FETCH_WIDTH = 4;
    localparam int ADDR_WIDTH  = 9;
    localparam int DEPTH       = 2 ** ADDR_WIDTH;
    localparam int IDX_WIDTH   = $clog2(FETCH_WIDTH);

    typedef logic [WORD_WIDTH-1:0]                  word_t;
    typedef logic [FETCH_WIDTH-1:0][WORD_WIDTH-1:0] line_t;

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_e;

endpackage

`default_nettype wire

// File: rtl/sram_line_serializer.sv
// ============================================================================
// Module : sram_line_serializer
// Brief  : Holds one SRAM line and hands it out word 0 first on valid/ready.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_line_serializer
    import sram_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  capture,
    input  line_t line_in,
    output logic  rd_valid,
    input  logic  rd_ready,
    output word_t rd_data,
    output logic  empty
);

    localparam logic [IDX_WIDTH-1:0] c_LAST_IDX = IDX_WIDTH'(FETCH_WIDTH - 1);

    line_t                r_buf;
    logic [IDX_WIDTH-1:0] r_idx;
    logic                 r_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (capture) begin
            r_buf   <= line_in;
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (r_valid && rd_ready) begin
            r_idx <= r_idx + IDX_WIDTH'(1);
            if (r_idx == c_LAST_IDX) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rd_valid = r_valid;
    assign rd_data  = r_buf[r_idx];
    assign empty    = !r_valid;

endmodule

`default_nettype wire

// File: rtl/sram_line_fifo_ctrl.sv
// ============================================================================
// Module : sram_line_fifo_ctrl
// Brief  : Packs words into lines, keeps them as a circular FIFO in a
//          single-port SRAM and streams them back out word by word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_line_fifo_ctrl
    import sram_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  word_t                 wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output word_t                 rd_data,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_cen,
    output logic                  sram_wen,
    output line_t                 sram_data_in,
    input  line_t                 sram_data_out,
    output logic [ADDR_WIDTH:0]   lines_stored
);

    localparam logic [IDX_WIDTH-1:0]  c_LAST_IDX = IDX_WIDTH'(FETCH_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0]   c_DEPTH    = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_ONE_LINE = (ADDR_WIDTH + 1)'(1);

    line_t                 r_agg;
    logic [IDX_WIDTH-1:0]  r_agg_cnt;
    logic                  r_agg_full;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_lines;
    logic                  r_in_flight;
    grant_e                r_last_grant;

    logic w_accept;
    logic w_buf_empty;
    logic w_wr_elig;
    logic w_rd_elig;
    logic w_grant_wr;
    logic w_grant_rd;
    logic w_do_wr;
    logic w_do_rd;

    assign w_accept  = wr_valid && !r_agg_full;
    assign w_wr_elig = r_agg_full && (r_lines < c_DEPTH);
    assign w_rd_elig = (r_lines != '0) && w_buf_empty && !r_in_flight;

    // Contention resolves to whichever side was not served last.
    assign w_grant_wr = w_wr_elig && (!w_rd_elig || (r_last_grant == GRANT_READ));
    assign w_grant_rd = w_rd_elig && (!w_wr_elig || (r_last_grant == GRANT_WRITE));

    // Keep the macro idle while reset is held, whatever the stale state says.
    assign w_do_wr = rst_n && w_grant_wr;
    assign w_do_rd = rst_n && w_grant_rd;

    assign wr_ready     = !r_agg_full;
    assign sram_cen     = w_do_wr || w_do_rd;
    assign sram_wen     = w_do_wr;
    assign sram_addr    = w_do_wr ? r_wr_ptr : (w_do_rd ? r_rd_ptr : '0);
    assign sram_data_in = r_agg;
    assign lines_stored = r_lines;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_agg        <= '0;
            r_agg_cnt    <= '0;
            r_agg_full   <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_lines      <= '0;
            r_in_flight  <= 1'b0;
            r_last_grant <= GRANT_READ;
        end else begin
            if (w_accept) begin
                r_agg[r_agg_cnt] <= wr_data;
                r_agg_cnt        <= r_agg_cnt + IDX_WIDTH'(1);
                if (r_agg_cnt == c_LAST_IDX) begin
                    r_agg_full <= 1'b1;
                end
            end
            if (w_grant_wr) begin
                r_wr_ptr     <= r_wr_ptr + ADDR_WIDTH'(1);
                r_agg_full   <= 1'b0;
                r_last_grant <= GRANT_WRITE;
                r_lines      <= r_lines + c_ONE_LINE;
            end
            if (w_grant_rd) begin
                r_rd_ptr     <= r_rd_ptr + ADDR_WIDTH'(1);
                r_last_grant <= GRANT_READ;
                r_lines      <= r_lines - c_ONE_LINE;
            end
            // Read data returns one cycle after issue; in-flight lasts exactly that cycle.
            r_in_flight <= w_grant_rd;
        end
    end

    sram_line_serializer u_serializer (
        .clk      (clk),
        .rst_n    (rst_n),
        .capture  (r_in_flight),
        .line_in  (sram_data_out),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .empty    (w_buf_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_sram_line_fifo_ctrl.sv
// ============================================================================
// Module : tb_sram_line_fifo_ctrl
// Brief  : Bench for sram_line_fifo_ctrl with an SRAM model and a queue-based
//          reference of the line FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_line_fifo_ctrl;
    import sram_ctrl_pkg::*;

    logic                  clk      = 1'b0;
    logic                  rst_n    = 1'b0;
    logic                  wr_valid = 1'b0;
    logic                  rd_ready = 1'b0;
    word_t                 wr_data  = '0;
    logic                  wr_ready;
    logic                  rd_valid;
    word_t                 rd_data;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic                  sram_cen;
    logic                  sram_wen;
    line_t                 sram_data_in;
    line_t                 sram_data_out;
    logic [ADDR_WIDTH:0]   lines_stored;

    int tests_run    = 0;
    int tests_failed = 0;

    sram_line_fifo_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .sram_addr     (sram_addr),
        .sram_cen      (sram_cen),
        .sram_wen      (sram_wen),
        .sram_data_in  (sram_data_in),
        .sram_data_out (sram_data_out),
        .lines_stored  (lines_stored)
    );

    always #5 clk = ~clk;

    // Single-port SRAM: read data appears the cycle after the read issue.
    line_t mem [DEPTH];
    always @(posedge clk) begin
        if (sram_cen) begin
            if (sram_wen) mem[sram_addr] <= sram_data_in;
            else          sram_data_out  <= mem[sram_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: words gathered into lines, lines queued as the SRAM contents,
    // the line being handed out kept as a word queue.
    word_t part_q[$];
    line_t pend_q[$];
    line_t stored_q[$];
    word_t out_q[$];
    int    cyc          = 0;
    int    out_rdy_cyc  = 0;
    int    wr_n         = 0;
    int    rd_n         = 0;
    int    reads_seen   = 0;
    bit    last_write   = 1'b0;
    int    exp_op;
    int    obs_op;
    logic  exp_valid;
    logic  exp_wrr;
    line_t rl;
    line_t nl;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("reset_cen", sram_cen, 1'b0);
            part_q.delete();
            pend_q.delete();
            stored_q.delete();
            out_q.delete();
            wr_n       = 0;
            rd_n       = 0;
            last_write = 1'b0;
        end else begin
            exp_wrr = (pend_q.size() == 0);
            if (pend_q.size() != 0 && stored_q.size() < DEPTH) begin
                if (stored_q.size() != 0 && out_q.size() == 0) exp_op = last_write ? 2 : 1;
                else                                           exp_op = 1;
            end else if (stored_q.size() != 0 && out_q.size() == 0) begin
                exp_op = 2;
            end else begin
                exp_op = 0;
            end
            obs_op    = !sram_cen ? 0 : (sram_wen ? 1 : 2);
            exp_valid = (out_q.size() != 0) && (cyc >= out_rdy_cyc);

            chk("lines_stored", lines_stored, stored_q.size());
            chk("wr_ready", wr_ready, exp_wrr);
            chk("rd_valid", rd_valid, exp_valid);
            chk("sram_op", obs_op, exp_op);

            if (exp_valid) begin
                chk("rd_data", rd_data, out_q[0]);
                if (rd_ready) void'(out_q.pop_front());
            end

            if (exp_op == 1) begin
                chk("wr_addr", sram_addr, wr_n % DEPTH);
                chk("wr_line", sram_data_in, pend_q[0]);
                stored_q.push_back(pend_q.pop_front());
                wr_n++;
                last_write = 1'b1;
            end else if (exp_op == 2) begin
                chk("rd_addr", sram_addr, rd_n % DEPTH);
                rl = stored_q.pop_front();
                for (int i = 0; i < FETCH_WIDTH; i++) out_q.push_back(rl[i]);
                out_rdy_cyc = cyc + 2;
                rd_n++;
                reads_seen++;
                last_write = 1'b0;
            end else begin
                chk("idle_addr_wen", {sram_addr, sram_wen}, '0);
            end

            if (wr_valid && exp_wrr) begin
                part_q.push_back(wr_data);
                if (part_q.size() == FETCH_WIDTH) begin
                    for (int i = 0; i < FETCH_WIDTH; i++) nl[i] = part_q[i];
                    pend_q.push_back(nl);
                    part_q.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input word_t d);
        logic acc;
        int   n;
        acc      = 1'b0;
        n        = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = wr_ready;
            tick();
            n++;
        end
        wr_valid = 1'b0;
        chk("push_accepted", acc, 1'b1);
    endtask

    task automatic drain(input int budget);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            done = (stored_q.size() == 0) && (out_q.size() == 0) && (pend_q.size() == 0);
            if (!done) tick();
            n++;
        end
        chk("drain_empty", done, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1);
    end

    initial begin
        int n;
        int r0;

        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("reset_wr_ready", wr_ready, 1'b1);
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_cen_after", sram_cen, 1'b0);
        chk("reset_lines", lines_stored, '0);

        // Single line: output latency from the 4th accepted word.
        rd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push(word_t'(i));
        n = 0;
        while (!rd_valid && n < 20) begin
            tick();
            n++;
        end
        chk("t1_latency", n, 3);
        chk("t1_first_word", rd_data, 16'h0001);
        drain(200);

        // Fill to capacity with the output stalled, then drain.
        rd_ready = 1'b0;
        for (int i = 0; i < 2056; i++) push(word_t'(16'h1000 + i));
        repeat (5) tick();
        chk("t2_full_lines", lines_stored, DEPTH);
        chk("t2_full_wr_ready", wr_ready, 1'b0);
        chk("t2_full_idle", sram_cen, 1'b0);
        rd_ready = 1'b1;
        drain(8000);

        // Long stream to wrap both pointers.
        for (int i = 0; i < 600 * FETCH_WIDTH; i++) push(word_t'(i * 7 + 3));
        drain(2000);

        // Random producer and consumer.
        for (int i = 0; i < 1500; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = word_t'($urandom);
            rd_ready = 1'($urandom_range(0, 1));
            tick();
        end
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        drain(2000);

        // Clear the leftover partial line, then reset with a read in flight.
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(word_t'(16'hA000 + i));
        repeat (10) tick();
        chk("t6_lines_before", lines_stored, 1);
        chk("t6_wr_ready_before", wr_ready, 1'b1);
        r0       = reads_seen;
        rd_ready = 1'b1;
        n        = 0;
        while (reads_seen == r0 && n < 50) begin
            tick();
            n++;
        end
        chk("t6_read_issued", reads_seen != r0, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_rd_valid", rd_valid, 1'b0);
        chk("t6_lines", lines_stored, '0);
        chk("t6_wr_ready", wr_ready, 1'b1);
        chk("t6_cen", sram_cen, 1'b0);
        repeat (3) tick();
        chk("t6_rd_valid_later", rd_valid, 1'b0);
        for (int i = 0; i < 4; i++) push(word_t'(16'hC000 + i));
        drain(200);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
